// File: rtl/led_wb_scan_if.sv
// Wishbone pipelined slave bus bundle for led_wb_scan.
// Signal names follow the block's external port naming so waveforms match the register map docs.
interface led_wb_scan_if;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [1:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_wb_stall;
    logic        o_wb_ack;
    logic [31:0] o_wb_data;

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        input  o_wb_stall, o_wb_ack, o_wb_data
    );

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        output o_wb_stall, o_wb_ack, o_wb_data
    );
endinterface

// File: rtl/led_wb_scan.sv
// Knight-rider LED scanner with a Wishbone register interface (CTRL/PRESCALE/COUNT/LEDS).
// Define LED_WB_SCAN_IRQ_EN to add the IE bit and the o_int sweep-done pulse.
module led_wb_scan #(
    parameter int            NLED      = 8,
    parameter int            PW        = 16,
    parameter logic [PW-1:0] RESET_DIV = '0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    led_wb_scan_if.slave    wb,
    output logic [NLED-1:0] o_led
`ifdef LED_WB_SCAN_IRQ_EN
    ,
    output logic            o_int
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    localparam logic [NLED-1:0] LED_ONE = NLED'(1);
    localparam logic [NLED-1:0] LED_TWO = NLED'(2);

    state_t          state_q, state_d;
    logic [NLED-1:0] led_q, led_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [PW-1:0]   div_q, div_d;
    logic [15:0]     count_q, count_d;
    logic            cont_q, cont_d;
    logic            ie_q;
    logic            ack_q;
    logic [31:0]     rdata_q, rdata_d;

    logic            accept, wr, ctrl_wr, start, stop;
    logic            tick, sweep_end, done;
    logic [NLED-1:0] led_shl, led_shr;
    logic            unused_wdata;

    assign accept    = wb.i_wb_cyc && wb.i_wb_stb;
    assign wr        = accept && wb.i_wb_we;
    assign ctrl_wr   = wr && (wb.i_wb_addr == 2'd0);
    assign start     = ctrl_wr && wb.i_wb_data[0];
    assign stop      = ctrl_wr && wb.i_wb_data[2];
    assign tick      = (div_q == '0) && (state_q != IDLE);
    assign led_shl   = led_q << 1;
    assign led_shr   = led_q >> 1;
    assign sweep_end = tick && (state_q == RIGHT) && (led_q == LED_ONE);
    // STOP beats a coincident completion, so neither COUNT nor the IRQ see it
    assign done      = sweep_end && !stop;
    assign unused_wdata = ^wb.i_wb_data;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = LEFT;
                LEFT:    if (tick && led_shl[NLED-1]) state_d = RIGHT;
                RIGHT:   if (sweep_end) state_d = cont_q ? LEFT : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        led_d   = led_q;
        div_d   = div_q;
        count_d = count_q;
        if (stop) begin
            led_d = '0;
            div_d = '0;
        end else if (state_q == IDLE) begin
            if (start) begin
                led_d = LED_ONE;
                div_d = presc_q;
            end
        end else if (tick) begin
            div_d = presc_q;
            if (state_q == LEFT) begin
                led_d = led_shl;
            end else if (sweep_end) begin
                led_d   = cont_q ? LED_TWO : '0;
                count_d = count_q + 16'd1;
            end else begin
                led_d = led_shr;
            end
        end else begin
            div_d = div_q - 1'b1;
        end
    end

    always_comb begin
        presc_d = presc_q;
        cont_d  = cont_q;
        rdata_d = rdata_q;
        if (wr && (wb.i_wb_addr == 2'd1)) presc_d = wb.i_wb_data[PW-1:0];
        if (ctrl_wr) cont_d = wb.i_wb_data[1];
        if (accept) begin
            case (wb.i_wb_addr)
                2'd0:    rdata_d = {26'b0, state_q, ie_q, 1'b0, cont_q, state_q != IDLE};
                2'd1:    rdata_d = 32'(presc_q);
                2'd2:    rdata_d = {16'b0, count_q};
                default: rdata_d = 32'(led_q);
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            led_q   <= '0;
            div_q   <= '0;
            count_q <= '0;
            presc_q <= RESET_DIV;
            cont_q  <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            led_q   <= led_d;
            div_q   <= div_d;
            count_q <= count_d;
            presc_q <= presc_d;
            cont_q  <= cont_d;
            ack_q   <= accept;
            rdata_q <= rdata_d;
        end
    end

`ifdef LED_WB_SCAN_IRQ_EN
    logic int_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ie_q  <= 1'b0;
            int_q <= 1'b0;
        end else begin
            if (ctrl_wr) ie_q <= wb.i_wb_data[3];
            int_q <= done && ie_q;
        end
    end

    assign o_int = int_q;
`else
    logic unused_done;
    assign ie_q        = 1'b0;
    assign unused_done = done;
`endif

    assign o_led         = led_q;
    assign wb.o_wb_stall = 1'b0;
    assign wb.o_wb_ack   = ack_q;
    assign wb.o_wb_data  = rdata_q;

endmodule

// File: doc/led_wb_scan.md
LED_WB_SCAN -- requirements
Module: led_wb_scan

Interface
REQ-001 Parameter NLED, default 8, LED count, legal range 2..32.
REQ-002 Parameter PW, default 16, prescaler width, legal range 1..32.
REQ-003 Parameter RESET_DIV, default 0, prescale register reset value, PW bits.
REQ-004 i_clk  in  1  sole clock; all logic on rising edge.
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  Wishbone pipelined bus cycle, strobe and write enable.
REQ-007 i_wb_addr  in  2  register select.
REQ-008 i_wb_data  in  32  write data.
REQ-009 o_wb_stall  out  1  SHALL be constant 0.
REQ-010 o_wb_ack  out  1  one-cycle acknowledge.
REQ-011 o_wb_data  out  32  read data, registered.
REQ-012 o_led  out  NLED  LED drive, registered.
REQ-013 o_int  out  1  sweep-done pulse; present only under LED_WB_SCAN_IRQ_EN.

Function
REQ-014 A request is accepted when i_wb_cyc && i_wb_stb; o_wb_ack SHALL assert exactly one cycle later, for every address.
REQ-015 o_wb_ack SHALL be 0 in any cycle following one where i_wb_cyc was low.
REQ-016 Register map: 0 CTRL, 1 PRESCALE, 2 COUNT, 3 LEDS. COUNT and LEDS are read-only, and writes to them are acked and ignored.
REQ-017 CTRL write: bit0 START, bit1 CONT, bit2 STOP, bit3 IE. CONT and IE are stored; START and STOP are self-clearing.
REQ-018 CTRL read: {26'b0, state[1:0], IE, 1'b0, CONT, busy}, where busy = (state != IDLE) and the low nibble is bit3 IE, bit2 0, bit1 CONT, bit0 busy.
REQ-019 Reads: PRESCALE is zero-extended; COUNT is {16'b0, sweep_count[15:0]}; LEDS is zero-extended o_led.
REQ-020 State machine: IDLE=0, LEFT=1, RIGHT=2.
REQ-021 Prescaler: a down-counter of PW bits. A tick occurs when it is 0 and state != IDLE; it then reloads PRESCALE. Steps therefore occur every PRESCALE+1 cycles.
REQ-022 START in IDLE: next cycle o_led=1, state=LEFT, prescaler loaded with PRESCALE.
REQ-023 START while busy SHALL be ignored.
REQ-024 LEFT tick: o_led shifts left one place; if the new MSB is set, state becomes RIGHT.
REQ-025 RIGHT tick with o_led != 1: o_led shifts right one place.
REQ-026 RIGHT tick with o_led == 1 completes a sweep: sweep_count increments, wrapping 0xFFFF->0.
REQ-027 On sweep completion with CONT=0: o_led=0, state=IDLE. A one-shot sweep is therefore 2*NLED-1 ticks from START to dark.
REQ-028 On sweep completion with CONT=1: o_led=2, state=LEFT, no dark gap.
REQ-029 STOP: next cycle o_led=0, state=IDLE, sweep_count unchanged.
REQ-030 STOP and START in the same write: STOP wins.
REQ-031 STOP coincident with a tick: STOP wins.
REQ-032 A PRESCALE write mid-sweep takes effect at the next reload.
REQ-033 A CTRL write clearing CONT mid-sweep applies at the next completion.
REQ-034 Read data SHALL reflect register values in the accept cycle.

Reset
REQ-035 On i_reset: state=IDLE, o_led=0, o_wb_ack=0, o_wb_data=0, CONT=0, IE=0, PRESCALE=RESET_DIV, prescaler=0, sweep_count=0, o_int=0.
REQ-036 Reset mid-sweep or mid-bus-cycle SHALL abort without an ack in the following cycle.

Configuration
REQ-037 With LED_WB_SCAN_IRQ_EN defined: o_int pulses high for one cycle, the cycle after any sweep completion, when IE=1.
REQ-038 Without LED_WB_SCAN_IRQ_EN: there is no o_int port, IE is not stored, and CTRL bit3 reads 0.

Verification
REQ-039 NLED=8, PRESCALE=0, write CTRL=1 -> ack next cycle; o_led 01,02,04..80,40..01,00 on consecutive cycles; COUNT reads 1.
REQ-040 PRESCALE=3, START -> each o_led value held exactly 4 cycles; total 15 steps, 60 cycles to dark.
REQ-041 CTRL=3 (CONT), run 2 sweeps, then write CTRL=4 -> after 01 comes 02 with no dark gap; o_led=0 the cycle after STOP; COUNT=2.
REQ-042 START while busy, then read CTRL -> sweep unaffected; reads busy=1, state=1 or 2.
REQ-043 Assert i_reset at step 5 of a sweep with a read in flight -> next cycle o_led=0, o_wb_ack=0, COUNT=0.
REQ-044 IRQ_EN, IE=1, one-shot sweep -> o_int high for exactly 1 cycle after completion; IE=0 -> o_int stays 0.
